// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: free-running AD7476-class SPI ADC frame engine; latches each result and pulses eoc_o once per frame
module adc_spi_sampler #(
   parameter int CLK_DIV      = 2,
   parameter int FRAME_BITS   = 16,
   parameter int DATA_BITS    = 12,
   parameter int QUIET_CYCLES = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 adc_miso_i,
   output logic                 adc_cs_no,
   output logic                 adc_sclk_o,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 eoc_o
);
   localparam int MAXC = CLK_DIV > QUIET_CYCLES ? CLK_DIV : QUIET_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int BW   = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
   if (CLK_DIV < 1 || QUIET_CYCLES < 1 || DATA_BITS < 1 || DATA_BITS > FRAME_BITS) begin : g_bad_params
      $fatal(1, "adc_spi_sampler: illegal parameter set");
   end
   typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;
   state_t                state, next_state;
   logic [CW-1:0]         div, next_div;
   logic [BW-1:0]         bits, next_bits;
   logic [FRAME_BITS-1:0] shreg, next_shreg;
   logic [DATA_BITS-1:0]  next_data;
   logic                  next_cs, next_sclk, next_eoc;
   logic                  half_end, last_bit, quiet_end;
   assign half_end  = div == CW'(CLK_DIV - 1);
   assign last_bit  = bits == BW'(FRAME_BITS - 1);
   // div is 0 in DONE, so DONE itself is quiet cycle 1 and QUIET_CYCLES==1 rearms straight from DONE
   assign quiet_end = div == CW'(QUIET_CYCLES - 1);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         div        <= '0;
         bits       <= '0;
         shreg      <= '0;
         adc_cs_no  <= 1'b1;
         adc_sclk_o <= 1'b0;
         data_o     <= '0;
         eoc_o      <= 1'b0;
      end else begin
         state      <= next_state;
         div        <= next_div;
         bits       <= next_bits;
         shreg      <= next_shreg;
         adc_cs_no  <= next_cs;
         adc_sclk_o <= next_sclk;
         data_o     <= next_data;
         eoc_o      <= next_eoc;
      end
   end
   always_comb begin
      next_state = state;
      next_div   = div;
      next_bits  = bits;
      next_shreg = shreg;
      next_cs    = adc_cs_no;
      next_sclk  = adc_sclk_o;
      next_data  = data_o;
      next_eoc   = 1'b0;
      case (state)
         IDLE: begin
            next_state = en_i ? SHIFT : IDLE;
            next_cs    = !en_i;
         end
         SHIFT: begin
            next_div = half_end ? '0 : div + CW'(1);
            if (half_end && !adc_sclk_o) begin
               next_sclk  = 1'b1;
               next_shreg = (shreg << 1) | FRAME_BITS'(adc_miso_i);
            end else if (half_end && last_bit) begin
               next_state = DONE;
               next_cs    = 1'b1;
               next_sclk  = 1'b0;
               next_bits  = '0;
               next_data  = shreg[DATA_BITS-1:0];
               next_eoc   = 1'b1;
            end else if (half_end) begin
               next_sclk = 1'b0;
               next_bits = bits + BW'(1);
            end
         end
         DONE, QUIET: begin
            next_div   = quiet_end ? '0 : div + CW'(1);
            next_state = quiet_end ? (en_i ? SHIFT : IDLE) : QUIET;
            next_cs    = quiet_end ? !en_i : 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: directed frames through an ADC word model; a scoreboard pairs each frame word with its eoc_o
module tb_adc_spi_sampler;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0, en_b = 1'b0;
   logic        miso;
   logic        cs_n, sclk, eoc, cs_b, sclk_b, eoc_b;
   logic [11:0] data, data_b;
   int          vectors = 0, errors = 0, cyc = 0;
   int          eoc_cnt = 0, falls_a = 0;
   int          low_a = 0, high_a = 0, last_low_a = 0, last_high_a = 0;
   int          lo_run = 0, hi_run = 0, rises_a = 0;
   int          low_b = 0, last_low_b = 0;
   logic        prev_cs_a = 1'b1, prev_sclk_a = 1'b0, prev_cs_b = 1'b1, prev_sclk_b = 1'b0;
   logic [11:0] prev_data = '0;
   logic [15:0] word = '0, tie_word = 16'h0555;
   logic [15:0] adc_q[$];
   logic [11:0] exp_q[$];
   int          eoc_t[$], eocb_t[$];

   adc_spi_sampler dut_a (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .adc_miso_i(miso),
      .adc_cs_no(cs_n), .adc_sclk_o(sclk), .data_o(data), .eoc_o(eoc));

   adc_spi_sampler #(.CLK_DIV(1), .QUIET_CYCLES(1)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .adc_miso_i(1'b1),
      .adc_cs_no(cs_b), .adc_sclk_o(sclk_b), .data_o(data_b), .eoc_o(eoc_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ADC presents frame bit k until the k-th SCLK rise of the frame
   assign miso = rises_a < 16 ? word[15 - rises_a] : 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_eocs(input int n, input int budget);
      int target, t;
      target = eoc_cnt + n;
      t = 0;
      while (eoc_cnt < target && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("eoc_within_budget", eoc_cnt >= target, 1);
   endtask

   task automatic wait_fall(input int budget);
      int target, t;
      target = falls_a + 1;
      t = 0;
      while (falls_a < target && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("cs_fall_within_budget", falls_a >= target, 1);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         low_a = 0; high_a = 0; lo_run = 0; hi_run = 0; rises_a = 0;
      end else begin
         if (!cs_n) begin
            if (prev_cs_a) begin
               last_high_a = high_a; high_a = 0; falls_a++; rises_a = 0;
               word = adc_q.size() > 0 ? adc_q.pop_front() : tie_word;
               exp_q.push_back(word[11:0]);
            end
            low_a++;
         end else begin
            if (!prev_cs_a) begin last_low_a = low_a; low_a = 0; end
            high_a++;
            check("sclk_idle_low", sclk, 0);
         end
         if (sclk && !prev_sclk_a) begin rises_a++; check("sclk_low_half", lo_run, 2); lo_run = 0; end
         if (!sclk && prev_sclk_a) begin check("sclk_high_half", hi_run, 2); hi_run = 0; end
         if (sclk) hi_run++;
         else if (!cs_n) lo_run++;
         if (eoc) begin
            eoc_cnt++;
            eoc_t.push_back(cyc);
            check("eoc_with_cs_rise", {prev_cs_a, cs_n}, 2'b01);
            check("cs_low_cycles", last_low_a, 64);
            check("sclk_rises_per_frame", rises_a, 16);
            check("eoc_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("data", data, exp_q.pop_front());
         end
         if (data !== prev_data) check("data_change_on_eoc", eoc, 1);
      end
      prev_cs_a = cs_n; prev_sclk_a = sclk; prev_data = data;
   end

   always @(negedge clk) begin
      if (!rst_n) low_b = 0;
      else begin
         if (!cs_b) begin
            if (!prev_cs_b) check("b_sclk_toggle", sclk_b ^ prev_sclk_b, 1);
            low_b++;
         end else if (!prev_cs_b) begin
            last_low_b = low_b; low_b = 0;
         end
         if (eoc_b) begin
            eocb_t.push_back(cyc);
            check("b_cs_low_cycles", last_low_b, 32);
            check("b_data", data_b, 12'hFFF);
         end
      end
      prev_cs_b = cs_b; prev_sclk_b = sclk_b;
   end

   initial begin
      int e, f, rel, t;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_cs", cs_n, 1);
      check("rst_sclk", sclk, 0);
      check("rst_data", data, 0);
      check("rst_eoc", eoc, 0);
      exp_q.delete();
      // single frame, then three back-to-back frames with en held
      adc_q.push_back(16'h0ABC);
      adc_q.push_back(16'h0123);
      adc_q.push_back(16'h0456);
      adc_q.push_back(16'h0789);
      en = 1'b1;
      wait_eocs(1, 80);
      check("t1_data", data, 12'hABC);
      wait_eocs(3, 230);
      for (int i = 1; i < eoc_t.size(); i++) check("eoc_period", eoc_t[i] - eoc_t[i-1], 69);
      check("cs_high_gap", last_high_a, 5);
      check("t2_data", data, 12'h789);
      // drop en mid-frame: frame must still complete once, then stay idle
      wait_fall(20);
      repeat (19) @(negedge clk);
      en = 1'b0;
      wait_eocs(1, 100);
      e = eoc_cnt;
      f = falls_a;
      repeat (150) @(negedge clk);
      check("no_extra_eoc", eoc_cnt, e);
      check("no_restart", falls_a, f);
      check("idle_cs", cs_n, 1);
      check("idle_sclk", sclk, 0);
      check("t3_data", data, 12'h555);
      // asynchronous reset 30 cycles into a frame
      en = 1'b1;
      wait_fall(10);
      repeat (30) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_cs", cs_n, 1);
      check("async_rst_sclk", sclk, 0);
      check("async_rst_data", data, 0);
      check("async_rst_eoc", eoc, 0);
      exp_q.delete();
      e = eoc_cnt;
      adc_q.push_back(16'hF3C5);
      adc_q.push_back(16'hFFFF);
      adc_q.push_back(16'h0000);
      adc_q.push_back(16'hF000);
      adc_q.push_back(16'h0FFF);
      repeat (3) @(negedge clk);
      check("no_eoc_in_reset", eoc_cnt, e);
      rst_n = 1'b1;
      rel = cyc;
      wait_eocs(1, 80);
      check("restart_latency", eoc_t[eoc_t.size()-1] - rel, 65);
      check("restart_data", data, 12'h3C5);
      // constant-ones / constant-zeros and leading-bit discard
      wait_eocs(4, 300);
      check("t5_last_data", data, 12'hFFF);
      check("scoreboard_drained", exp_q.size(), 0);
      en = 1'b0;
      repeat (80) @(negedge clk);
      // fastest configuration on the second instance
      en_b = 1'b1;
      t = 0;
      while (eocb_t.size() < 3 && t < 150) begin
         @(negedge clk);
         t++;
      end
      check("b_eoc_count", eocb_t.size() >= 3, 1);
      for (int i = 1; i < eocb_t.size(); i++) check("b_eoc_period", eocb_t[i] - eocb_t[i-1], 33);
      en_b = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
